// File: rtl/clock_monitor.sv
// Frequency/period monitor for an asynchronous square wave: counts rising edges
// per gate window, measures the interval between edges, and flags range and loss of signal.
module clock_monitor #(
    parameter int BUS_WIDTH    = 32,
    parameter int FREQ_IN      = 25000000,
    parameter int GATE_CYCLES  = 25000,
    parameter int EXPECTED_CNT = 1000,
    parameter int TOLERANCE    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sig_in,
    output logic [BUS_WIDTH-1:0] freq_cnt,
    output logic                 freq_valid,
    output logic                 in_range,
    output logic [BUS_WIDTH-1:0] period_cnt,
    output logic                 period_valid,
    output logic                 stopped
);

    if (GATE_CYCLES < 2 || FREQ_IN <= 0 || BUS_WIDTH < 2) begin : g_bad_params
        $error("clock_monitor: invalid parameter set");
    end

    localparam logic [BUS_WIDTH-1:0] GATE_LAST = BUS_WIDTH'(GATE_CYCLES - 1);
    localparam logic [BUS_WIDTH:0]   EXP_W     = (BUS_WIDTH+1)'(EXPECTED_CNT);
    localparam logic [BUS_WIDTH:0]   TOL_W     = (BUS_WIDTH+1)'(TOLERANCE);
    // One extra bit keeps EXPECTED+TOLERANCE from wrapping; the lower bound clamps at zero.
    localparam logic [BUS_WIDTH:0]   RANGE_LO  = (EXP_W >= TOL_W) ? (EXP_W - TOL_W) : '0;
    localparam logic [BUS_WIDTH:0]   RANGE_HI  = EXP_W + TOL_W;

    typedef enum logic {
        ARM,
        MEASURE
    } state_t;

    state_t               state;
    logic                 sync1, sync2, hist;
    logic                 sig_rise;
    logic                 seen_edge;
    logic [BUS_WIDTH-1:0] gate_cnt;
    logic [BUS_WIDTH-1:0] edge_cnt;
    logic [BUS_WIDTH-1:0] edge_next;
    logic [BUS_WIDTH-1:0] per_cnt;

    function automatic logic [BUS_WIDTH-1:0] sat_inc(input logic [BUS_WIDTH-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    function automatic logic in_window(input logic [BUS_WIDTH-1:0] cnt);
        logic [BUS_WIDTH:0] c;
        c = {1'b0, cnt};
        return (c >= RANGE_LO) && (c <= RANGE_HI);
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign sig_rise = sync2 & ~hist;

    always_comb begin
        edge_next = edge_cnt;
        if (sig_rise) edge_next = sat_inc(edge_cnt);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ARM;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_cnt   <= '0;
            freq_valid <= 1'b0;
            in_range   <= 1'b0;
            stopped    <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            unique case (state)
                ARM: begin
                    if (sig_rise) begin
                        state    <= MEASURE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        stopped  <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        freq_cnt   <= '0;
                        in_range   <= in_window('0);
                        freq_valid <= 1'b1;
                        stopped    <= 1'b1;
                        gate_cnt   <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    // An edge on the closing cycle is folded into this window's result.
                    if (gate_cnt == GATE_LAST) begin
                        freq_cnt   <= edge_next;
                        in_range   <= in_window(edge_next);
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        if (edge_next == '0) begin
                            stopped <= 1'b1;
                            state   <= ARM;
                        end else begin
                            stopped <= 1'b0;
                        end
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        edge_cnt <= edge_next;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            per_cnt      <= '0;
            seen_edge    <= 1'b0;
            period_cnt   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sig_rise) begin
                per_cnt   <= '0;
                seen_edge <= 1'b1;
                if (seen_edge) begin
                    period_cnt   <= sat_inc(per_cnt);
                    period_valid <= 1'b1;
                end
            end else begin
                per_cnt <= sat_inc(per_cnt);
            end
        end
    end

endmodule
